msrv32_rf_write_arbiter: RTL and testbench
==========================================

# msrv32_rf_write_arbiter

Write-side front end of the integer register file. Merges the in-order pipeline writeback (stage 3) with results from a variable-latency source (load/store unit or multi-cycle unit) onto the file's single write port. Late results are buffered in a small FIFO, and the pipeline is stalled if they starve. Sits between stage 3 / LSU and the register file's rd_addr_in/wr_en_in/rd_in inputs, and reports pending-write hazards back to stage 2.

## Interface
- DEPTH, 2: late-result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4: consecutive pipeline-granted cycles, with the FIFO non-empty, before a forced drain.
- clock  in  1  system clock, rising edge.
- reset_in  in  1  synchronous, active-high reset; one clock, reset_in is synchronous and active-high.
- pipe_wr_en_in  in  1  pipeline writeback request.
- pipe_rd_addr_in  in  5  pipeline destination register.
- pipe_rd_in  in  32  pipeline write data.
- lsu_valid_in  in  1  late result valid.
- lsu_ready_out  out  1  FIFO can accept; equals !full.
- lsu_rd_addr_in  in  5  late result destination.
- lsu_data_in  in  32  late result data.
- stall_out  out  1  pipeline must hold stage-3 outputs this cycle.
- rs_1_addr_in, rs_2_addr_in  in  5 each  stage-2 source addresses.
- busy_rs1_out, busy_rs2_out  out  1 each  source has a write pending in the FIFO.
- wr_en_out  out  1  registered write enable to the register file.
- rd_addr_out  out  5  registered write address to the register file.
- rd_out  out  32  registered write data to the register file.

## Operation
- **LSU handshake:** a transfer occurs when lsu_valid_in && lsu_ready_out. A transfer with lsu_rd_addr_in==0 is accepted and discarded, never enqueued.
- **lsu_ready_out:** depends only on FIFO occupancy, never on same-cycle dequeue. When full, ready=0 even if a dequeue happens that cycle.
- **Grant priority each cycle:**
  1. stall_out=1: grant FIFO head.
  2. Otherwise, pipe_wr_en_in && pipe_rd_addr_in!=0: grant pipeline.
  3. Otherwise, FIFO non-empty: grant FIFO head.
  4. Otherwise, idle.
- **x0 writes:** pipeline writes to x0 are dropped; wr_en_out stays 0 for them.
- **Stall contract:** while stall_out=1, pipe_wr_en_in is ignored. The pipeline holds and re-presents the same write the next cycle, so no write is lost.
- **Starvation counter (cnt, 0..STARVE_LIMIT):**
  - Increments when the pipeline is granted while the FIFO is non-empty.
  - Clears when the FIFO is granted or the FIFO is empty.
  - stall_out = (cnt==STARVE_LIMIT), decoded from registered state.
  - The stall cycle grants the FIFO and clears cnt, so stall_out lasts exactly one cycle.
- **Hazard flags:** busy_rsN_out = rs_N_addr_in!=0 and it matches the rd_addr of any valid FIFO entry.
  - Combinational.
  - Excludes the same-cycle LSU transfer.
  - Excludes the output register, which the file forwards itself.
  - Stage 2 stalls on busy.
- **Same-cycle enqueue and dequeue (non-full):** occupancy is unchanged; the FIFO order is preserved.
- **Write ordering:** two FIFO entries to the same register are written in arrival order.

## Timing
- **Latency:** a granted write appears on wr_en_out/rd_addr_out/rd_out on the next rising edge, valid for exactly one cycle.
- **LSU pass-through:** latency is ≥2 cycles (enqueue edge, then grant/output edge).
- **Idle cycles:** wr_en_out=0; rd_addr_out/rd_out hold their previous values.
- **Reset values:**
  - wr_en_out=0, rd_addr_out=0, rd_out=0.
  - FIFO empty, cnt=0, stall_out=0.
  - lsu_ready_out=1 and busy_rs*_out=0 from the first cycle after reset.
- **Reset mid-operation:** FIFO contents are discarded and no write is emitted in the reset cycle. Any LSU handshake in the reset cycle is lost; the LSU must re-issue.
- **Throughput:**
  - One register-file write per cycle maximum.
  - LSU sustains one result per cycle when the pipeline is idle.
  - Worst-case FIFO drain is one entry per STARVE_LIMIT+1 cycles under continuous pipeline writes.

## Structure
- **Shared package msrv32_pkg:**
  - XLEN=32
  - REG_ADDR_W=5
  - REG_ZERO=5'd0
- **Sub-module msrv32_wb_fifo:**
  - Parameterised DEPTH × (REG_ADDR_W+XLEN) FIFO.
  - Count-based full/empty and wrapping pointers.
  - Exposes per-entry valid and addr vectors for the busy compare.
- Arbitration, starvation counter and output register live in the top.

## Test plan
- **Pipeline only:** pipe write x5=0xDEADBEEF at cycle 0 → wr_en_out=1, rd_addr_out=5, rd_out=0xDEADBEEF at cycle 1; a pipe write to x0 → wr_en_out stays 0.
- **LSU only:** x7=0x1234 handshake at cycle 0 with pipeline idle → written at cycle 2; busy_rs1_out=1 during cycle 1 with rs_1_addr_in=7, then 0.
- **Fill and wrap:** DEPTH=2, continuous pipe writes, LSU presents x1, x2, x3 → lsu_ready_out=0 after two transfers; x3 is accepted only after the first drain; written order is x1, x2, x3.
- **Starvation:** FIFO holds x9=0xA5, with pipe writes every cycle → pipeline wins 4 cycles, then stall_out=1 for one cycle, x9=0xA5 is written, and the held pipe write is written on the following cycle.
- **Simultaneous full dequeue/enqueue:** FIFO full, a FIFO grant and lsu_valid_in in the same cycle → no transfer; the transfer succeeds next cycle.
- **Reset mid-operation:** reset with 2 FIFO entries and stall_out=1 → next cycle all outputs are 0, lsu_ready_out=1, and no stale write is ever emitted.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared integer-core widths and the hard-wired zero register address.
package msrv32_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/msrv32_wb_fifo.sv
// Late-result FIFO holding {rd_addr, data}; per-entry valid/addr exposed for the hazard compare.
module msrv32_wb_fifo
    import msrv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset_in,
    input  logic                        push_in,
    input  logic [REG_ADDR_W-1:0]       push_addr_in,
    input  logic [XLEN-1:0]             push_data_in,
    input  logic                        pop_in,
    output logic                        full_out,
    output logic                        empty_out,
    output logic [REG_ADDR_W-1:0]       head_addr_out,
    output logic [XLEN-1:0]             head_data_out,
    output logic [DEPTH-1:0]            entry_valid_out,
    output logic [DEPTH*REG_ADDR_W-1:0] entry_addr_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [REG_ADDR_W-1:0] addr_d [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic [XLEN-1:0]       data_d [DEPTH];
    logic                  do_push, do_pop;
    logic [PTR_W-1:0]      offset;

    assign full_out      = (count_q == CNT_W'(DEPTH));
    assign empty_out     = (count_q == '0);
    assign do_push       = push_in && !full_out;
    assign do_pop        = pop_in && !empty_out;
    assign head_addr_out = addr_q[rd_ptr_q];
    assign head_data_out = data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (do_push) begin
            addr_d[wr_ptr_q] = push_addr_in;
            data_d[wr_ptr_q] = push_data_in;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        offset          = '0;
        entry_valid_out = '0;
        entry_addr_out  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset                                 = PTR_W'(i) - rd_ptr_q;
            entry_valid_out[i]                     = ({1'b0, offset} < count_q);
            entry_addr_out[i*REG_ADDR_W +: REG_ADDR_W] = addr_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: rtl/msrv32_rf_write_arbiter.sv
// Merges stage-3 writeback and buffered late results onto the single register-file write port.
module msrv32_rf_write_arbiter
    import msrv32_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_in,
    input  logic                  pipe_wr_en_in,
    input  logic [REG_ADDR_W-1:0] pipe_rd_addr_in,
    input  logic [XLEN-1:0]       pipe_rd_in,
    input  logic                  lsu_valid_in,
    output logic                  lsu_ready_out,
    input  logic [REG_ADDR_W-1:0] lsu_rd_addr_in,
    input  logic [XLEN-1:0]       lsu_data_in,
    output logic                  stall_out,
    input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
    input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
    output logic                  busy_rs1_out,
    output logic                  busy_rs2_out,
    output logic                  wr_en_out,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic [XLEN-1:0]       rd_out
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                        fifo_full, fifo_empty, fifo_push;
    logic [REG_ADDR_W-1:0]       head_addr;
    logic [XLEN-1:0]             head_data;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH*REG_ADDR_W-1:0] entry_addr;
    logic                        pipe_grant, fifo_grant;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]             rd_q, rd_d;

    // x0 results complete the handshake but never occupy an entry.
    assign lsu_ready_out = !fifo_full;
    assign fifo_push     = lsu_valid_in && !fifo_full && (lsu_rd_addr_in != REG_ZERO);

    assign stall_out  = (cnt_q == CNT_W'(STARVE_LIMIT));
    assign pipe_grant = !stall_out && pipe_wr_en_in && (pipe_rd_addr_in != REG_ZERO);
    assign fifo_grant = !fifo_empty && (stall_out || !pipe_grant);

    msrv32_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock           (clock),
        .reset_in        (reset_in),
        .push_in         (fifo_push),
        .push_addr_in    (lsu_rd_addr_in),
        .push_data_in    (lsu_data_in),
        .pop_in          (fifo_grant),
        .full_out        (fifo_full),
        .empty_out       (fifo_empty),
        .head_addr_out   (head_addr),
        .head_data_out   (head_data),
        .entry_valid_out (entry_valid),
        .entry_addr_out  (entry_addr)
    );

    always_comb begin
        cnt_d     = (pipe_grant && !fifo_empty) ? cnt_q + CNT_W'(1) : '0;
        wr_en_d   = pipe_grant || fifo_grant;
        rd_addr_d = rd_addr_q;
        rd_d      = rd_q;
        if (pipe_grant) begin
            rd_addr_d = pipe_rd_addr_in;
            rd_d      = pipe_rd_in;
        end else if (fifo_grant) begin
            rd_addr_d = head_addr;
            rd_d      = head_data;
        end
    end

    always_comb begin
        busy_rs1_out = 1'b0;
        busy_rs2_out = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == rs_1_addr_in)
                busy_rs1_out = 1'b1;
            if (entry_valid[i] && entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == rs_2_addr_in)
                busy_rs2_out = 1'b1;
        end
        busy_rs1_out = busy_rs1_out && (rs_1_addr_in != REG_ZERO);
        busy_rs2_out = busy_rs2_out && (rs_2_addr_in != REG_ZERO);
    end

    always_ff @(posedge clock) begin
        if (reset_in) begin
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
        end
    end

    assign wr_en_out   = wr_en_q;
    assign rd_addr_out = rd_addr_q;
    assign rd_out      = rd_q;
endmodule

// File: tb/tb_msrv32_rf_write_arbiter.sv
// Directed bench: expected writes are queued with their due cycle and checked every clock.
module tb_msrv32_rf_write_arbiter;
    logic        clock = 1'b0;
    logic        reset_in;
    logic        pipe_wr_en_in;
    logic [4:0]  pipe_rd_addr_in;
    logic [31:0] pipe_rd_in;
    logic        lsu_valid_in;
    logic        lsu_ready_out;
    logic [4:0]  lsu_rd_addr_in;
    logic [31:0] lsu_data_in;
    logic        stall_out;
    logic [4:0]  rs_1_addr_in, rs_2_addr_in;
    logic        busy_rs1_out, busy_rs2_out;
    logic        wr_en_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_out;

    msrv32_rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock           (clock),
        .reset_in        (reset_in),
        .pipe_wr_en_in   (pipe_wr_en_in),
        .pipe_rd_addr_in (pipe_rd_addr_in),
        .pipe_rd_in      (pipe_rd_in),
        .lsu_valid_in    (lsu_valid_in),
        .lsu_ready_out   (lsu_ready_out),
        .lsu_rd_addr_in  (lsu_rd_addr_in),
        .lsu_data_in     (lsu_data_in),
        .stall_out       (stall_out),
        .rs_1_addr_in    (rs_1_addr_in),
        .rs_2_addr_in    (rs_2_addr_in),
        .busy_rs1_out    (busy_rs1_out),
        .busy_rs2_out    (busy_rs2_out),
        .wr_en_out       (wr_en_out),
        .rd_addr_out     (rd_addr_out),
        .rd_out          (rd_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          at;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expw(input int n, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.at = cyc + n; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    // Advance one clock and check the registered write port against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            chk("wr_en", {31'd0, wr_en_out}, 32'd1);
            chk("wr_addr", {27'd0, rd_addr_out}, {27'd0, e.addr});
            chk("wr_data", rd_out, e.data);
        end else begin
            chk("wr_en_idle", {31'd0, wr_en_out}, 32'd0);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_wr_en_in = pw; pipe_rd_addr_in = pa; pipe_rd_in = pd;
        lsu_valid_in = lv; lsu_rd_addr_in = la; lsu_data_in = ld;
        #1;
    endtask

    initial begin
        reset_in = 1'b1;
        rs_1_addr_in = 5'd0; rs_2_addr_in = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clock); @(posedge clock); #1;
        reset_in = 1'b0;
        #1;
        chk("rst_wr_en", {31'd0, wr_en_out}, 32'd0);
        chk("rst_addr", {27'd0, rd_addr_out}, 32'd0);
        chk("rst_data", rd_out, 32'd0);
        chk("rst_ready", {31'd0, lsu_ready_out}, 32'd1);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_busy1", {31'd0, busy_rs1_out}, 32'd0);

        // pipeline only, then an x0 write that must be dropped
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0); expw(1, 5, 32'hDEADBEEF); tick();
        drive(1, 0, 32'h11111111, 0, 0, 0); tick();
        chk("hold_addr", {27'd0, rd_addr_out}, 32'd5);
        chk("hold_data", rd_out, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0); tick();

        // LSU only: busy during the buffered cycle, two-cycle latency
        rs_1_addr_in = 5'd7; rs_2_addr_in = 5'd3;
        drive(0, 0, 0, 1, 7, 32'h1234);
        chk("busy_same_cycle", {31'd0, busy_rs1_out}, 32'd0);
        expw(2, 7, 32'h1234); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("busy_rs1_buf", {31'd0, busy_rs1_out}, 32'd1);
        chk("busy_rs2_other", {31'd0, busy_rs2_out}, 32'd0);
        tick();
        chk("busy_rs1_clear", {31'd0, busy_rs1_out}, 32'd0);
        // LSU write to x0 is accepted and discarded
        rs_1_addr_in = 5'd0;
        drive(0, 0, 0, 1, 0, 32'hBAD0); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("x0_ready", {31'd0, lsu_ready_out}, 32'd1);
        tick();

        // fill and wrap under continuous pipe writes; full + stall grant blocks a transfer
        rs_1_addr_in = 5'd1; rs_2_addr_in = 5'd2;
        drive(1, 10, 32'hA0, 1, 1, 32'hB1); expw(1, 10, 32'hA0); tick();
        drive(1, 11, 32'hA1, 1, 2, 32'hB2); expw(1, 11, 32'hA1); tick();
        drive(1, 12, 32'hA2, 1, 3, 32'hB3);
        chk("full_ready", {31'd0, lsu_ready_out}, 32'd0);
        chk("full_busy1", {31'd0, busy_rs1_out}, 32'd1);
        chk("full_busy2", {31'd0, busy_rs2_out}, 32'd1);
        expw(1, 12, 32'hA2); tick();
        drive(1, 13, 32'hA3, 1, 3, 32'hB3); expw(1, 13, 32'hA3); tick();
        drive(1, 14, 32'hA4, 1, 3, 32'hB3);
        chk("pre_stall", {31'd0, stall_out}, 32'd0);
        expw(1, 14, 32'hA4); tick();
        drive(1, 15, 32'hA5, 1, 3, 32'hB3);
        chk("fill_stall", {31'd0, stall_out}, 32'd1);
        chk("full_deq_ready", {31'd0, lsu_ready_out}, 32'd0);
        expw(1, 1, 32'hB1); tick();
        drive(1, 15, 32'hA5, 1, 3, 32'hB3);
        chk("after_stall", {31'd0, stall_out}, 32'd0);
        chk("drain_ready", {31'd0, lsu_ready_out}, 32'd1);
        expw(1, 15, 32'hA5); tick();
        drive(0, 0, 0, 0, 0, 0); expw(1, 2, 32'hB2); tick();
        expw(1, 3, 32'hB3); tick();
        tick();

        // starvation: four pipe wins, one stall cycle, then the held pipe write
        rs_1_addr_in = 5'd9;
        drive(0, 0, 0, 1, 9, 32'hA5); tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(16 + i), 32'hC0 + 32'(i), 0, 0, 0);
            chk("starve_no_stall", {31'd0, stall_out}, 32'd0);
            chk("starve_busy", {31'd0, busy_rs1_out}, 32'd1);
            expw(1, 5'(16 + i), 32'hC0 + 32'(i)); tick();
        end
        drive(1, 21, 32'hC5, 0, 0, 0);
        chk("starve_stall", {31'd0, stall_out}, 32'd1);
        expw(1, 9, 32'hA5); tick();
        chk("starve_one_cycle", {31'd0, stall_out}, 32'd0);
        expw(1, 21, 32'hC5); tick();
        drive(0, 0, 0, 0, 0, 0); tick();

        // reset with a full FIFO and stall asserted
        drive(1, 10, 32'hE0, 1, 1, 32'hF1); expw(1, 10, 32'hE0); tick();
        drive(1, 11, 32'hE1, 1, 2, 32'hF2); expw(1, 11, 32'hE1); tick();
        for (int i = 2; i <= 4; i++) begin
            drive(1, 5'(10 + i), 32'hE0 + 32'(i), 0, 0, 0);
            expw(1, 5'(10 + i), 32'hE0 + 32'(i)); tick();
        end
        drive(1, 15, 32'hE5, 1, 4, 32'hF4);
        chk("rst_pre_stall", {31'd0, stall_out}, 32'd1);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_rst_addr", {27'd0, rd_addr_out}, 32'd0);
        chk("mid_rst_data", rd_out, 32'd0);
        chk("mid_rst_ready", {31'd0, lsu_ready_out}, 32'd1);
        chk("mid_rst_stall", {31'd0, stall_out}, 32'd0);
        chk("mid_rst_busy1", {31'd0, busy_rs1_out}, 32'd0);
        for (int i = 0; i < 4; i++) tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
